// File: rtl/mem_wb_reg_way1_pkg.sv
// Shared way1 types: write-back payload, widths and the buffer occupancy encoding.
package b8_way1_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned PID_W      = 2;

  typedef struct packed {
    logic                  rdWriteEnable;
    logic [REG_ADDR_W-1:0] rdAddr;
    logic [XLEN-1:0]       rdData;
    logic [PID_W-1:0]      way1_pID;
  } wb_payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2,
    ST_BAD   = 2'd3
  } buf_state_e;

  // Occupancy follows directly from the two valid flags; skid without main is illegal.
  function automatic buf_state_e buf_state(input logic main_v, input logic skid_v);
    if (!main_v && !skid_v)     return ST_EMPTY;
    else if (main_v && !skid_v) return ST_ONE;
    else if (main_v && skid_v)  return ST_FULL;
    else                        return ST_BAD;
  endfunction

endpackage

// File: rtl/mem_wb_reg_way1_if.sv
// MEM->WB way1 handshake bundle: upstream push side, downstream pop side and flush.
interface mem_wb_reg_way1_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned PID_W  = 2
);
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic              rdWriteEnable_i;
  logic [ADDR_W-1:0] rdAddr_i;
  logic [DATA_W-1:0] rdData_i;
  logic [PID_W-1:0]  way1_pID_i;
  logic              valid_o;
  logic              ready_i;
  logic              rdWriteEnable_o;
  logic [ADDR_W-1:0] rdAddr_o;
  logic [DATA_W-1:0] rdData_o;
  logic [PID_W-1:0]  way1_pID_o;

  modport master (
    output flush_i, valid_i, rdWriteEnable_i, rdAddr_i, rdData_i, way1_pID_i, ready_i,
    input  ready_o, valid_o, rdWriteEnable_o, rdAddr_o, rdData_o, way1_pID_o
  );

  modport slave (
    input  flush_i, valid_i, rdWriteEnable_i, rdAddr_i, rdData_i, way1_pID_i, ready_i,
    output ready_o, valid_o, rdWriteEnable_o, rdAddr_o, rdData_o, way1_pID_o
  );
endinterface

// File: rtl/mem_wb_reg_way1_skid_buffer.sv
// Two-entry skid buffer (main + skid) whose ready and valid come straight from flops.
module skid_buffer
  import b8_way1_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic       main_v;
  logic       skid_v;
  T           main_q;
  T           skid_q;
  logic       acc;
  logic       pop;
  buf_state_e state;

  assign state     = buf_state(main_v, skid_v);
  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_data  = main_q;
  assign acc       = in_valid & in_ready;
  assign pop       = main_v & out_ready;

  // Payload flops only load on accept or skid->main move; flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            main_q <= in_data;
            main_v <= 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            main_q <= in_data;
          end else if (acc) begin
            skid_q <= in_data;
            skid_v <= 1'b1;
          end else if (pop) begin
            main_v <= 1'b0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_q <= skid_q;
            skid_v <= 1'b0;
          end
        end
        default: begin
          main_v <= main_v;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_reg_way1.sv
// Way1 MEM->WB pipeline register: packs the retiring result into a skid buffer.
module mem_wb_reg_way1 #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned PID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_wb_reg_way1_if.slave   bus
);

  localparam int unsigned P_XLEN = b8_way1_pkg::XLEN;
  localparam int unsigned P_AW   = b8_way1_pkg::REG_ADDR_W;
  localparam int unsigned P_PW   = b8_way1_pkg::PID_W;

  b8_way1_pkg::wb_payload_t in_pl;
  b8_way1_pkg::wb_payload_t out_pl;
  logic                     rdy;
  logic                     vld;

  always_comb begin
    in_pl.rdWriteEnable = bus.rdWriteEnable_i;
    in_pl.rdAddr        = P_AW'(bus.rdAddr_i);
    in_pl.rdData        = P_XLEN'(bus.rdData_i);
    in_pl.way1_pID      = P_PW'(bus.way1_pID_i);
  end

  skid_buffer #(.T(b8_way1_pkg::wb_payload_t)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush_i),
    .in_valid  (bus.valid_i),
    .in_ready  (rdy),
    .in_data   (in_pl),
    .out_valid (vld),
    .out_ready (bus.ready_i),
    .out_data  (out_pl)
  );

  assign bus.ready_o         = rdy;
  assign bus.valid_o         = vld;
  assign bus.rdWriteEnable_o = out_pl.rdWriteEnable;
  assign bus.rdAddr_o        = ADDR_W'(out_pl.rdAddr);
  assign bus.rdData_o        = DATA_W'(out_pl.rdData);
  assign bus.way1_pID_o      = PID_W'(out_pl.way1_pID);

endmodule

// File: tb/tb_mem_wb_reg_way1.sv
// Bench for mem_wb_reg_way1: directed vector table, flush/reset sequences, random vs FIFO model.
module tb_mem_wb_reg_way1;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned PW = 2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [PW-1:0] pid;
  } pl_t;

  typedef struct {
    logic r;
    logic f;
    logic v;
    pl_t  pl;
    logic rd;
    logic ev;
    logic er;
    logic cpl;
    pl_t  epl;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_reg_way1_if #(.DATA_W(DW), .ADDR_W(AW), .PID_W(PW)) bus ();
  mem_wb_reg_way1 #(.DATA_W(DW), .ADDR_W(AW), .PID_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   ncmp = 0;
  int   nbad = 0;
  pl_t  mq[$];
  vec_t vt[$];

  function automatic pl_t mk(input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [PW-1:0] p);
    return {we, a, d, p};
  endfunction

  function automatic pl_t dut_pl();
    return {bus.rdWriteEnable_o, bus.rdAddr_o, bus.rdData_o, bus.way1_pID_o};
  endfunction

  function automatic void add(input logic r, input logic f, input logic v, input pl_t p,
                              input logic rd, input logic ev, input logic er,
                              input logic cpl, input pl_t ep);
    vec_t x;
    x.r = r; x.f = f; x.v = v; x.pl = p; x.rd = rd;
    x.ev = ev; x.er = er; x.cpl = cpl; x.epl = ep;
    vt.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the depth-2 FIFO model at the edge, then compare after the edge.
  task automatic cycle(input logic r, input logic f, input logic v, input pl_t p, input logic rd);
    logic acc, pop, stall;
    pl_t  pre_pl;
    rst                 = r;
    bus.flush_i         = f;
    bus.valid_i         = v;
    bus.rdWriteEnable_i = p.we;
    bus.rdAddr_i        = p.addr;
    bus.rdData_i        = p.data;
    bus.way1_pID_i      = p.pid;
    bus.ready_i         = rd;
    stall  = bus.valid_o && !rd && !r && !f;
    pre_pl = dut_pl();
    @(posedge clk);
    if (r || f) begin
      mq.delete();
    end else begin
      acc = v && (mq.size() < 2);
      pop = (mq.size() > 0) && rd;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(p);
    end
    @(negedge clk);
    chk("valid_o", 128'(bus.valid_o), 128'(mq.size() > 0));
    chk("ready_o", 128'(bus.ready_o), 128'(mq.size() < 2));
    if (mq.size() > 0) chk("payload", 128'(dut_pl()), 128'(mq[0]));
    if (stall) begin
      chk("stall_valid", 128'(bus.valid_o), 128'(1'b1));
      chk("stall_payload", 128'(dut_pl()), 128'(pre_pl));
    end
  endtask

  pl_t z, a, b, c, p0;

  initial begin
    z  = '0;
    a  = mk(1'b1, 5'd3, 64'hAAAA_0000_0000_000A, 2'd1);
    b  = mk(1'b0, 5'd9, 64'hBBBB_0000_0000_000B, 2'd3);
    c  = mk(1'b1, 5'd17, 64'hCCCC_0000_0000_000C, 2'd0);
    p0 = mk(1'b1, 5'd5, 64'h1234, 2'd2);

    rst = 1'b1;
    bus.flush_i = 1'b0; bus.valid_i = 1'b0; bus.ready_i = 1'b0;
    bus.rdWriteEnable_i = 1'b0; bus.rdAddr_i = '0; bus.rdData_i = '0; bus.way1_pID_i = '0;

    // Reset, single transfer, then empty.
    add(1, 0, 0, z,  1, 0, 1, 1, z);
    add(0, 0, 1, p0, 1, 1, 1, 1, p0);
    add(0, 0, 0, z,  1, 0, 1, 0, z);
    // Streaming: data 0..7 back-to-back, ready_o stays high.
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, mk(1'b1, 5'(i), 64'(i), 2'(i)), 1, 1, 1, 1, mk(1'b1, 5'(i), 64'(i), 2'(i)));
    add(0, 0, 0, z, 1, 0, 1, 0, z);
    // Back-pressure: A held, ready_o drops after B, then A, B drain in order.
    add(0, 0, 1, a, 0, 1, 1, 1, a);
    add(0, 0, 1, b, 0, 1, 0, 1, a);
    add(0, 0, 1, c, 0, 1, 0, 1, a);
    add(0, 0, 0, z, 1, 1, 1, 1, b);
    add(0, 0, 0, z, 1, 0, 1, 0, z);

    for (int i = 0; i < vt.size(); i++) begin
      cycle(vt[i].r, vt[i].f, vt[i].v, vt[i].pl, vt[i].rd);
      chk($sformatf("tbl%0d_valid", i), 128'(bus.valid_o), 128'(vt[i].ev));
      chk($sformatf("tbl%0d_ready", i), 128'(bus.ready_o), 128'(vt[i].er));
      if (vt[i].cpl) chk($sformatf("tbl%0d_payload", i), 128'(dut_pl()), 128'(vt[i].epl));
    end

    // Flush while FULL drops A, B and the concurrent C.
    cycle(0, 0, 1, a, 0);
    cycle(0, 0, 1, b, 0);
    chk("full_ready", 128'(bus.ready_o), 128'(1'b0));
    cycle(0, 1, 1, c, 0);
    chk("flush_valid", 128'(bus.valid_o), 128'(1'b0));
    chk("flush_ready", 128'(bus.ready_o), 128'(1'b1));
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, z, 1);
      chk("flush_no_out", 128'(bus.valid_o), 128'(1'b0));
    end

    // Reset while FULL returns everything to reset values; next push behaves as fresh.
    cycle(0, 0, 1, a, 0);
    cycle(0, 0, 1, b, 0);
    cycle(1, 0, 1, c, 0);
    chk("rstfull_valid", 128'(bus.valid_o), 128'(1'b0));
    chk("rstfull_ready", 128'(bus.ready_o), 128'(1'b1));
    chk("rstfull_payload", 128'(dut_pl()), 128'(z));
    cycle(0, 0, 1, p0, 1);
    chk("post_rst_valid", 128'(bus.valid_o), 128'(1'b1));
    chk("post_rst_payload", 128'(dut_pl()), 128'(p0));
    cycle(0, 0, 0, z, 1);
    chk("post_rst_empty", 128'(bus.valid_o), 128'(1'b0));

    // Random valid/ready with rare flush and reset.
    for (int i = 0; i < 10000; i++) begin
      pl_t rp;
      rp = mk(1'($urandom), 5'($urandom), {32'($urandom), 32'($urandom)}, 2'($urandom));
      cycle(1'($urandom_range(0, 999) == 0),
            1'($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 2) != 0),
            rp,
            1'($urandom_range(0, 3) > ((i / 500) % 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
